// File: rtl/seq_multiplier_pkg.sv
// Shared types and constants for the sequential shift-and-add multiplier.
package seq_multiplier_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    localparam int DEF_WIDTH = 4;

    // Counter must hold values up to WIDTH (remaining-shift arithmetic uses WIDTH itself)
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/seq_mult_ctrl.sv
// Controller FSM for seq_multiplier: sequences load, WIDTH add/shift steps and result write.
// The early-exit request comes from the datapath and is simply tied low when unused.
module seq_mult_ctrl
    import seq_multiplier_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    localparam int CW = cnt_width(WIDTH)
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          start,
    input  logic          q_lsb,
    input  logic          early,
    output logic          load,
    output logic          add,
    output logic          shift,
    output logic          done,
    output logic          ready,
    output logic [CW-1:0] cnt
);

    state_t state;

    // State, step counter and registered ready level
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state <= IDLE;
            cnt   <= '0;
            ready <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= CALC;
                        cnt   <= '0;
                        ready <= 1'b0;
                    end
                end
                CALC: begin
                    cnt <= cnt + 1'b1;
                    if (early || cnt == CW'(WIDTH - 1)) state <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                    ready <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    ready <= 1'b1;
                end
            endcase
        end
    end

    // An early-exit step performs only the final alignment, never an add
    assign load  = (state == IDLE) && start;
    assign shift = (state == CALC);
    assign add   = shift && q_lsb && !early;
    assign done  = (state == DONE);

endmodule

// File: rtl/seq_multiplier.sv
// Sequential unsigned shift-and-add multiplier (datapath + output register).
// Optional feature: define SEQ_MULT_EARLY_EXIT_EN to finish as soon as the
// remaining multiplier bits are zero, aligning {A,Q} in a single step.
module seq_multiplier
    import seq_multiplier_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic [WIDTH-1:0]   x,
    input  logic [WIDTH-1:0]   y,
    input  logic               start,
    output logic [2*WIDTH-1:0] product,
    output logic               ready
);

    localparam int CW = cnt_width(WIDTH);

    logic [WIDTH-1:0]   m_r;
    logic [WIDTH-1:0]   q_r;
    logic [WIDTH:0]     a_r;
    logic [WIDTH:0]     a_nxt;
    logic [2*WIDTH:0]   aq_sh;
    logic [CW-1:0]      cnt;
    logic [CW-1:0]      rem;
    logic               load, add, shift, done, early;

    seq_mult_ctrl #(.WIDTH(WIDTH)) u_ctrl (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .start  (start),
        .q_lsb  (q_r[0]),
        .early  (early),
        .load   (load),
        .add    (add),
        .shift  (shift),
        .done   (done),
        .ready  (ready),
        .cnt    (cnt)
    );

    // Shifts still owed when leaving CALC early
    assign rem = CW'(WIDTH) - cnt;

`ifdef SEQ_MULT_EARLY_EXIT_EN
    logic [WIDTH-1:0] rem_mask;
    // Unshifted multiplier bits sit in the low WIDTH-cnt bits of Q
    assign rem_mask = {WIDTH{1'b1}} >> cnt;
    assign early    = shift && ((q_r & rem_mask) == '0);
`else
    assign early    = 1'b0;
`endif

    // Conditional add of M, then one-bit shift (or full alignment on early exit)
    always_comb begin
        a_nxt = add ? (a_r + {1'b0, m_r}) : a_r;
        aq_sh = early ? ({a_r, q_r} >> rem) : ({a_nxt, q_r} >> 1);
    end

    // Operand/accumulator registers and the result register
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            m_r     <= '0;
            q_r     <= '0;
            a_r     <= '0;
            product <= '0;
        end else begin
            if (load) begin
                m_r <= x;
                q_r <= y;
                a_r <= '0;
            end else if (shift) begin
                {a_r, q_r} <= aq_sh;
            end
            if (done) product <= {a_r[WIDTH-1:0], q_r};
        end
    end

endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboard bench for seq_multiplier: expected products are queued on accept
// and compared when ready rises.
module tb_seq_multiplier;

    localparam int W = 4;

    logic             clk_in = 1'b0;
    logic             rst_in;
    logic             start;
    logic [W-1:0]     x, y;
    logic [2*W-1:0]   product;
    logic             ready;

    always #5 clk_in = ~clk_in;

    seq_multiplier #(.WIDTH(W)) dut (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .x       (x),
        .y       (y),
        .start   (start),
        .product (product),
        .ready   (ready)
    );

    int n_vec = 0, n_err = 0;
    int cyc = 0, acc_cyc = 0, rise_cyc = 0, last_lat = 0, n_res = 0;
    bit inflight = 1'b0, stream = 1'b0, rise_ok = 1'b0;
    logic [2*W-1:0] sb[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Accept monitor: pre-edge values of ready/start decide acceptance
    always @(posedge clk_in) begin
        cyc++;
        if (rst_in) begin
            sb.delete();
            inflight = 1'b0;
        end else if (ready && start) begin
            sb.push_back((2*W)'(x) * (2*W)'(y));
            if (stream && rise_ok) chk("idle_gap", cyc - rise_cyc, 1);
            acc_cyc  = cyc;
            inflight = 1'b1;
        end
    end

    // Result monitor: ready rising ends the in-flight operation
    always @(negedge clk_in) begin
        if (inflight && ready) begin
            inflight = 1'b0;
            last_lat = cyc - acc_cyc;
            rise_cyc = cyc;
            rise_ok  = stream;
            n_res++;
            if (sb.size() == 0) chk("sb_underflow", 1, 0);
            else chk("product", product, sb.pop_front());
`ifdef SEQ_MULT_EARLY_EXIT_EN
            chk("latency_max", last_lat <= W + 1, 1);
`else
            chk("latency", last_lat, W + 1);
`endif
        end
    end

    task automatic wait_ready(input int max);
        for (int i = 0; i < max && !ready; i++) @(negedge clk_in);
        if (!ready) chk("ready_timeout", 0, 1);
        #1;
    endtask

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b);
        wait_ready(20);
        x = a; y = b; start = 1'b1;
        @(negedge clk_in);
        start = 1'b0;
        chk("busy_after_accept", ready, 0);
        wait_ready(20);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_in = 1'b1; start = 1'b0; x = '0; y = '0;
        repeat (2) @(negedge clk_in);
        rst_in = 1'b0;
        chk("rst_ready", ready, 1);
        chk("rst_product", product, 0);

        // Directed products
        do_op(4'b1010, 4'b0001);
        chk("first_lat_bound", last_lat <= W + 1, 1);
        do_op(15, 15);
        do_op(0, 9);
        do_op(7, 0);

        // Start while busy is ignored; operands change mid-flight
        wait_ready(20);
        x = 6; y = 5; start = 1'b1;
        @(negedge clk_in); start = 1'b0;
        @(negedge clk_in);
        @(negedge clk_in);
        x = 9; y = 9; start = 1'b1;
        @(negedge clk_in); start = 1'b0;
        wait_ready(20);
        chk("ignored_start_result", product, 30);
        @(negedge clk_in);
        chk("no_queued_op", ready, 1);
        chk("sb_drained", sb.size(), 0);

        // Reset mid-operation aborts without writing a result
        x = 11; y = 13; start = 1'b1;
        @(negedge clk_in); start = 1'b0;
        @(negedge clk_in);
        rst_in = 1'b1;
        @(negedge clk_in);
        rst_in = 1'b0;
        chk("midrst_ready", ready, 1);
        chk("midrst_product", product, 0);
        do_op(3, 5);
        chk("post_rst_result", product, 15);

        // Back-to-back stream with operands re-randomised every cycle
        begin
            int res0;
            res0    = n_res;
            stream  = 1'b1;
            rise_ok = 1'b0;
            start   = 1'b1;
            for (int i = 0; i < 3000 && (n_res - res0) < 200; i++) begin
                @(negedge clk_in);
                x = W'($urandom_range(0, 15));
                y = W'($urandom_range(0, 15));
            end
            start = 1'b0;
            chk("stream_count", (n_res - res0) >= 200, 1);
            wait_ready(20);
            @(negedge clk_in);
            stream = 1'b0;
        end

`ifdef SEQ_MULT_EARLY_EXIT_EN
        do_op(13, 1);
        chk("ee_result", product, 13);
        chk("ee_fast", last_lat < W + 1, 1);
        do_op(9, 0);
        chk("ee_y0_result", product, 0);
        chk("ee_y0_lat", last_lat, 2);
`endif

        repeat (2) @(negedge clk_in);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
